uart_sender: RTL and testbench

Counterpart of the UART receive path. It drains 32-bit words from the DDR3 read-FIFO user port and serialises each word as FIFO_RD_BYTE RS232 bytes (8N1, most-significant byte first) on one `tx` line, so the host PC can read back frame-buffer contents at the same baud rate used to load them. It sits on `clk_fifo` beside `uart_receiver`, connected to the `rd_en`/`rd_data`/`rd_valid` side of `ddr_interface`.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_byte_tx.sv | 145 ++++++++++++++
 rtl/uart_sender.sv | 96 +++++++++
 tb/tb_uart_sender.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_sender and uart_receiver.
// UART_SENDER_PARITY_EN adds the PARITY state and the 11-bit frame.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd5
`ifdef UART_SENDER_PARITY_EN
        , ST_PARITY = 3'd6
`endif
    } uart_state_e;

    localparam int FRAME_BITS_8N1    = 10;
    localparam int FRAME_BITS_PARITY = 11;

`ifdef UART_SENDER_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

    function automatic int bit_cyc(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one byte: start, d0..d7 LSB first, optional even parity, stop.
// UART_SENDER_PARITY_EN inserts the parity bit between d7 and stop.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BIT_CYC = 54
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       tx_o
);

    localparam int              CNT_W     = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYC - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
`ifdef UART_SENDER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);
    assign tx_o    = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_SENDER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_SENDER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Handshake: start_i is taken in IDLE or in the last STOP cycle (done_o high),
    // so the next byte follows the stop bit with no idle gap.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_SENDER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_START;
                    baud_d   = '0;
                    bit_d    = '0;
                    shift_d  = byte_i;
`ifdef UART_SENDER_PARITY_EN
                    parity_d = ^byte_i;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_SENDER_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (start_i) begin
                        state_d  = ST_START;
                        bit_d    = '0;
                        shift_d  = byte_i;
`ifdef UART_SENDER_PARITY_EN
                        parity_d = ^byte_i;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx is registered, so its next value follows the next state.
    always_comb begin
        done_o = (state_q == ST_STOP) && bit_end;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_SENDER_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_sender.sv
// Drains 32-bit read-FIFO words and sends them MSB byte first as RS232 frames.
// UART_SENDER_PARITY_EN selects 8E1 framing in uart_byte_tx.
module uart_sender
    import uart_pkg::*;
#(
    parameter int UART_BPS      = 'd460800,
    parameter int CLK_FREQ      = 'd25_000_000,
    parameter int FIFO_RD_WIDTH = 'd32,
    parameter int FIFO_RD_BYTE  = 'd4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tx_enable,
    input  logic                     fifo_rd_valid,
    input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
    output logic                     fifo_rd_en,
    output logic                     tx,
    output logic                     tx_busy
);

    localparam int               BIT_CYC   = bit_cyc(CLK_FREQ, UART_BPS);
    localparam int               BCNT_W    = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(FIFO_RD_BYTE - 1);

    uart_state_e              state_q, state_d;
    logic [BCNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [FIFO_RD_WIDTH-1:0] word_q, word_d;
    logic                     rd_en_q, rd_en_d;
    logic                     byte_start, byte_done;
    logic [7:0]               byte_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            rd_en_q    <= rd_en_d;
        end
    end

    // ST_DATA here means "bytes of the captured word are on the line".
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        case (state_q)
            ST_IDLE:  if (tx_enable && fifo_rd_valid) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                word_d     = fifo_rd_data << 8;
                byte_cnt_d = '0;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                if (byte_done) begin
                    if (byte_cnt_q != BYTE_LAST) begin
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                        word_d     = word_q << 8;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first byte goes straight from the FIFO bus; the rest come from word_q.
    always_comb begin
        byte_start = (state_q == ST_LOAD) ||
                     ((state_q == ST_DATA) && byte_done && (byte_cnt_q != BYTE_LAST));
        byte_data  = (state_q == ST_LOAD) ? fifo_rd_data[FIFO_RD_WIDTH-1 -: 8]
                                          : word_q[FIFO_RD_WIDTH-1 -: 8];
        rd_en_d    = (state_d == ST_FETCH);
        tx_busy    = (state_q != ST_IDLE);
    end

    assign fifo_rd_en = rd_en_q;

    uart_byte_tx #(
        .BIT_CYC (BIT_CYC)
    ) u_byte_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (byte_start),
        .byte_i  (byte_data),
        .done_o  (byte_done),
        .tx_o    (tx)
    );

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender at BIT_CYC=10; define UART_SENDER_PARITY_EN for the 8E1 build.
module tb_uart_sender;

    localparam int W = 32;
`ifdef UART_SENDER_PARITY_EN
    localparam int FRAME_CYC = 110;
`else
    localparam int FRAME_CYC = 100;
`endif
    localparam int WORD_CYC = 4 * FRAME_CYC;

    logic         clk, rst_n, tx_enable, fifo_rd_valid, fifo_rd_en, tx, tx_busy;
    logic [W-1:0] fifo_rd_data;

    uart_sender #(
        .UART_BPS      (100_000),
        .CLK_FREQ      (1_000_000),
        .FIFO_RD_WIDTH (32),
        .FIFO_RD_BYTE  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_enable     (tx_enable),
        .fifo_rd_valid (fifo_rd_valid),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .tx            (tx),
        .tx_busy       (tx_busy)
    );

    typedef struct {
        logic [31:0]     word;
        logic [3:0][7:0] bytes;
        logic [3:0]      par;
    } vec_t;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           rd_cnt = 0;
    int           busy_fall_cnt = 0;
    int           last_rd_cyc = 0;
    int           last_busy_fall = 0;
    int           start_q[$];
    logic         par_seen[$];
    logic [7:0]   exp_q[$];
    logic [W-1:0] fifo_q[$];
    logic         tx_hist[int];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- FIFO model and event recorder ----------------
    initial begin
        logic prev_busy;
        prev_busy     = 1'b0;
        fifo_rd_valid = 1'b0;
        fifo_rd_data  = '0;
        forever begin
            @(negedge clk);
            tx_hist[cyc] = tx;
            if (fifo_rd_en === 1'b1) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            end
            if (prev_busy && !tx_busy) begin
                busy_fall_cnt++;
                last_busy_fall = cyc;
            end
            prev_busy     = tx_busy;
            fifo_rd_valid = (fifo_q.size() != 0);
        end
    end

    // ---------------- line monitor / scoreboard ----------------
    initial begin
        logic [7:0] b;
        logic       stop_b;
        logic       p;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cyc);
                abort = 0;
                p     = 1'b0;
                repeat (4) @(negedge clk);
                if (!rst_n) abort = 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    if (!rst_n) abort = 1;
                    b[i] = tx;
                end
`ifdef UART_SENDER_PARITY_EN
                repeat (10) @(negedge clk);
                if (!rst_n) abort = 1;
                p = tx;
`endif
                repeat (10) @(negedge clk);
                if (!rst_n) abort = 1;
                stop_b = tx;
                if (!abort) begin
                    par_seen.push_back(p);
                    check("stop_bit", {31'd0, stop_b}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h with nothing expected", b);
                    end else begin
                        check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_busy_falls(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (busy_fall_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy_fall_cnt >= target}, 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (start_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, start_q.size() >= target}, 32'd1);
    endtask

    task automatic push_word_exp(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[31-8*k -: 8]);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[4];

    initial begin
        int rd0, s0, bf, p0, t;
        logic [31:0] w;

        vecs[0] = '{32'hA53C_0F81, {8'hA5, 8'h3C, 8'h0F, 8'h81}, 4'b0000};
        vecs[1] = '{32'h0103_0700, {8'h01, 8'h03, 8'h07, 8'h00}, 4'b1010};
        vecs[2] = '{32'hDEAD_BEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 4'b0101};
        vecs[3] = '{32'h8000_0001, {8'h80, 8'h00, 8'h00, 8'h01}, 4'b1001};

        // Reset held with a word available and enable high.
        rst_n     = 1'b0;
        tx_enable = 1'b1;
        fifo_q.push_back(32'h1111_1111);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            check("reset_outputs", {29'd0, tx, fifo_rd_en, tx_busy}, 32'b100);
        end
        tx_enable = 1'b0;
        fifo_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven single words.
        for (int v = 0; v < 4; v++) begin
            rd0 = rd_cnt;
            s0  = start_q.size();
            bf  = busy_fall_cnt;
            p0  = par_seen.size();
            for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].bytes[3-k]);
            fifo_q.push_back(vecs[v].word);
            tx_enable = 1'b1;
            wait_busy_falls(bf + 1, 2 * WORD_CYC, "vec_done");
            tx_enable = 1'b0;
            repeat (5) @(negedge clk);
            check("vec_rd_pulses", rd_cnt - rd0, 1);
            if (start_q.size() >= s0 + 4) begin
                t = start_q[s0];
                check("vec_rd_to_start", t - last_rd_cyc, 2);
                for (int k = 1; k < 4; k++)
                    check("vec_frame_len", start_q[s0+k] - start_q[s0+k-1], FRAME_CYC);
                check("vec_word_len", last_busy_fall - t, WORD_CYC);
                if (v == 0) begin
                    check("a5_start_last", {31'd0, tx_hist[t+9]}, 32'd0);
                    check("a5_d0_first", {31'd0, tx_hist[t+10]}, 32'd1);
                    check("a5_d0_last", {31'd0, tx_hist[t+19]}, 32'd1);
                    check("a5_d1_first", {31'd0, tx_hist[t+20]}, 32'd0);
                end
            end else begin
                check("vec_start_count", start_q.size() - s0, 4);
            end
`ifdef UART_SENDER_PARITY_EN
            for (int k = 0; k < 4; k++) begin
                if (par_seen.size() > p0 + k)
                    check("vec_parity", {31'd0, par_seen[p0+k]}, {31'd0, vecs[v].par[3-k]});
                else
                    check("vec_parity_count", par_seen.size() - p0, 4);
            end
`endif
        end

        // Random words.
        for (int r = 0; r < 3; r++) begin
            w   = $urandom();
            rd0 = rd_cnt;
            s0  = start_q.size();
            bf  = busy_fall_cnt;
            push_word_exp(w);
            fifo_q.push_back(w);
            tx_enable = 1'b1;
            wait_busy_falls(bf + 1, 2 * WORD_CYC, "rand_done");
            tx_enable = 1'b0;
            repeat (5) @(negedge clk);
            check("rand_rd_pulses", rd_cnt - rd0, 1);
            if (start_q.size() > s0) check("rand_word_len", last_busy_fall - start_q[s0], WORD_CYC);
        end

        // Back-to-back words.
        rd0 = rd_cnt;
        s0  = start_q.size();
        bf  = busy_fall_cnt;
        push_word_exp(32'h0000_0000);
        push_word_exp(32'hFFFF_FFFF);
        fifo_q.push_back(32'h0000_0000);
        fifo_q.push_back(32'hFFFF_FFFF);
        tx_enable = 1'b1;
        wait_busy_falls(bf + 2, 3 * WORD_CYC, "b2b_done");
        tx_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_rd_pulses", rd_cnt - rd0, 2);
        if (start_q.size() >= s0 + 8) begin
            check("b2b_gap", start_q[s0+4] - start_q[s0+3], FRAME_CYC + 3);
            check("b2b_total", last_busy_fall - start_q[s0], 2 * WORD_CYC + 3);
        end else begin
            check("b2b_start_count", start_q.size() - s0, 8);
        end

        // Enable dropped mid-word with three words queued.
        rd0 = rd_cnt;
        s0  = start_q.size();
        bf  = busy_fall_cnt;
        push_word_exp(32'h5A5A_0001);
        fifo_q.push_back(32'h5A5A_0001);
        fifo_q.push_back(32'h5A5A_0002);
        fifo_q.push_back(32'h5A5A_0003);
        tx_enable = 1'b1;
        wait_starts(s0 + 1, 50, "drop_first_start");
        repeat (50) @(negedge clk);
        tx_enable = 1'b0;
        wait_busy_falls(bf + 1, 2 * WORD_CYC, "drop_done");
        repeat (100) @(negedge clk);
        check("drop_rd_pulses", rd_cnt - rd0, 1);
        check("drop_fifo_left", fifo_q.size(), 2);
        check("drop_idle", {31'd0, tx_busy}, 32'd0);
        fifo_q.delete();
        repeat (2) @(negedge clk);

        // Reset during d3 of the second byte.
        s0 = start_q.size();
        push_word_exp(32'h1234_5678);
        fifo_q.push_back(32'h1234_5678);
        tx_enable = 1'b1;
        wait_starts(s0 + 1, 50, "rst_first_start");
        if (start_q.size() > s0) begin
            t = start_q[s0];
            while (cyc < t + 145) @(negedge clk);
            #1;
            check("rst_pre_tx_low", {31'd0, tx}, 32'd0);
            rst_n = 1'b0;
            #1;
            check("rst_async_outputs", {29'd0, tx, fifo_rd_en, tx_busy}, 32'b100);
        end else begin
            rst_n = 1'b0;
        end
        tx_enable = 1'b0;
        fifo_q.push_back(32'hC300_FF5A);
        repeat (15) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            repeat (10) @(negedge clk);
            check("post_rst_no_read", rd_cnt - rd0, 0);
            check("post_rst_tx_high", {31'd0, tx}, 32'd1);
        end
        bf = busy_fall_cnt;
        push_word_exp(32'hC300_FF5A);
        tx_enable = 1'b1;
        wait_busy_falls(bf + 1, 2 * WORD_CYC, "post_rst_done");
        tx_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_rd_pulses", rd_cnt - rd0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
